// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding.
// Encoding 2'd3 is unused and the controller recovers from it to S_IDLE.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell; the single arithmetic resource the sequencer time-shares.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: runs a WIDTH-bit add LSB-first through one full_adder,
// then presents sum/cout with a one-cycle done pulse.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s, fa_co;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_sr_shift;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign sum_sr_shift = (sum_sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_RUN : S_IDLE;
      S_RUN:   state_d = last_bit ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, commit result on the last bit.
  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d   = a;
          b_sr_d   = b;
          c_d      = cin;
          cnt_d    = '0;
          sum_sr_d = '0;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        c_d      = fa_co;
        sum_sr_d = sum_sr_shift;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d  = sum_sr_shift;
          cout_d = fa_co;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for sequencing checks
// and a 2-bit instance swept over every operand/carry combination.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] held8;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; issues one 1-cycle start and checks the full timeline.
  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [7:0] es, input logic ec);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = ~ta; b8 = ~tb; cin8 = ~tc;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s busy[%0d]", tag, i), 32'(busy8), 32'd1);
      check($sformatf("%s done[%0d]", tag, i), 32'(done8), 32'd0);
      check($sformatf("%s sumhold[%0d]", tag, i), 32'(sum8), 32'(held8));
      @(negedge clk);
    end
    check({tag, " done"}, 32'(done8), 32'd1);
    check({tag, " busy_off"}, 32'(busy8), 32'd0);
    check({tag, " sum"}, 32'(sum8), 32'(es));
    check({tag, " cout"}, 32'(cout8), 32'(ec));
    held8 = es;
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done8), 32'd0);
    check({tag, " sum_after"}, 32'(sum8), 32'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int         acc_cyc[$];
    logic [8:0] exp_q[$];
    logic [7:0] cur_a, cur_b;
    logic       cur_c, prev_busy;
    logic [8:0] e;
    int         n_done;
    logic [4:0] vv;

    // Reset with start asserted: nothing may be accepted
    rst = 1'b1; start8 = 1'b1; a8 = 8'h5A; b8 = 8'h25; cin8 = 1'b0;
    start2 = 1'b1; a2 = 2'd3; b2 = 2'd3; cin2 = 1'b1;
    held8 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst busy", 32'(busy8), 32'd0);
    check("rst done", 32'(done8), 32'd0);
    check("rst sum", 32'(sum8), 32'd0);
    check("rst cout", 32'(cout8), 32'd0);
    check("rst w2 busy", 32'(busy2), 32'd0);
    check("rst w2 sum", 32'({cout2, sum2}), 32'd0);
    rst = 1'b0; start8 = 1'b0; start2 = 1'b0;
    @(negedge clk);
    check("post_rst idle", 32'(busy8), 32'd0);

    // Basic add and carry chain
    run8("add5a25", 8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0);
    run8("ff01",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("ffff1",   8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start held high, operands changing every cycle
    cur_a = 8'h3C; cur_b = 8'hE1; cur_c = 1'b1;
    a8 = cur_a; b8 = cur_b; cin8 = cur_c; start8 = 1'b1;
    prev_busy = 1'b0; n_done = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (busy8 && !prev_busy) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(9'(cur_a) + 9'(cur_b) + 9'(cur_c));
      end
      if (done8) begin
        n_done++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
        check($sformatf("hold res%0d", n_done), 32'({cout8, sum8}), 32'(e));
        held8 = e[7:0];
      end else begin
        check($sformatf("hold sum c%0d", cyc), 32'(sum8), 32'(held8));
      end
      prev_busy = busy8;
      cur_a = 8'(cyc * 37 + 5);
      cur_b = 8'(cyc * 91 + 3);
      cur_c = cyc[0];
      a8 = cur_a; b8 = cur_b; cin8 = cur_c;
      start8 = (cyc < 29);
    end
    start8 = 1'b0;
    check("hold n_accept", 32'(acc_cyc.size()), 32'd3);
    check("hold n_done", 32'(n_done), 32'd3);
    if (acc_cyc.size() >= 3) begin
      check("hold interval1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
      check("hold interval2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
    end
    @(negedge clk);

    // Abort mid-run at cnt==3
    a8 = 8'h5A; b8 = 8'h25; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort sum", 32'(sum8), 32'd0);
    check("abort cout", 32'(cout8), 32'd0);
    held8 = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("abort nodone%0d", i), 32'({busy8, done8}), 32'd0);
    end
    run8("post_abort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // WIDTH=2 exhaustive sweep
    for (int v = 0; v < 32; v++) begin
      vv = 5'(v);
      a2 = vv[4:3]; b2 = vv[2:1]; cin2 = vv[0]; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      check($sformatf("w2 v%0d busy1", v), 32'({busy2, done2}), 32'd2);
      @(negedge clk);
      check($sformatf("w2 v%0d busy2", v), 32'({busy2, done2}), 32'd2);
      @(negedge clk);
      check($sformatf("w2 v%0d done", v), 32'({busy2, done2}), 32'd1);
      check($sformatf("w2 v%0d result", v), 32'({cout2, sum2}),
            32'(3'(vv[4:3]) + 3'(vv[2:1]) + 3'(vv[0])));
      @(negedge clk);
      check($sformatf("w2 v%0d idle", v), 32'({busy2, done2}), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
